// File: rtl/servo_pwm_pkg.sv
// Shared constants and width helpers for the servo PWM bank.
package servo_pwm_pkg;

   localparam int CLK_HZ           = 128000;
   localparam int DEF_PERIOD_TICKS = CLK_HZ / 50;    // 20 ms frame
   localparam int DEF_MIN_TICKS    = CLK_HZ / 2000;  // 0.5 ms minimum pulse
   localparam int MAX_CH           = 32;

   function automatic int cnt_width(input int period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/servo_pwm_cmp.sv
// One servo channel: shadow/dirty staging, frame-committed active duty and
// enable, comparator against the shared frame counter, registered pulse.
module servo_pwm_cmp
   import servo_pwm_pkg::*;
#(
   parameter int DUTY_W    = 8,
   parameter int CNT_W     = 12,
   parameter int MIN_TICKS = DEF_MIN_TICKS
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_i,
   input  logic [DUTY_W-1:0] wdata_i,
   input  logic              commit_i,
   input  logic              en_i,
   input  logic [CNT_W-1:0]  cnt_i,
   output logic              dirty_o,
   output logic              pwm_o
);

   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_TICKS);

   logic [DUTY_W-1:0] shadow_q, shadow_d;
   logic [DUTY_W-1:0] active_q, active_d;
   logic              dirty_q, dirty_d;
   logic              en_q, en_d;
   logic              pwm_q, pwm_d;

   // A write on the commit cycle wins the shadow and stays dirty; the active
   // register takes the value that was staged before it.
   always_comb begin
      shadow_d = wr_i ? wdata_i : shadow_q;
      dirty_d  = wr_i | (dirty_q & ~commit_i);
      active_d = (commit_i && dirty_q) ? shadow_q : active_q;
      en_d     = commit_i ? en_i : en_q;
      pwm_d    = en_q && (cnt_i < (MIN_C + CNT_W'(active_q)));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         active_q <= '0;
         dirty_q  <= 1'b0;
         en_q     <= 1'b0;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         dirty_q  <= dirty_d;
         en_q     <= en_d;
         pwm_q    <= pwm_d;
      end
   end

   assign dirty_o = dirty_q;
   assign pwm_o   = pwm_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of servo PWM channels sharing one frame counter; duty and enable
// updates are staged and committed together on the last tick of each frame.
module servo_pwm_bank
   import servo_pwm_pkg::*;
#(
   parameter int NUM_CH       = 8,
   parameter int DUTY_W       = 8,
   parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
   parameter int MIN_TICKS    = DEF_MIN_TICKS,
   localparam int CH_W        = sel_width(NUM_CH)
) (
   input  logic              clkdiv,
   input  logic              rst,
   input  logic              load,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic [DUTY_W-1:0] dutycycle,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_start,
   output logic              pending
);

   localparam int CNT_W = cnt_width(PERIOD_TICKS);

   if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("servo_pwm_bank: NUM_CH must be within 1..32");
   end
   if (MIN_TICKS + (1 << DUTY_W) - 1 >= PERIOD_TICKS) begin : g_bad_timing
      $error("servo_pwm_bank: longest pulse does not fit inside the frame");
   end

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              commit;
   logic              fs_q, fs_d;
   logic              pend_q, pend_d;
   logic [NUM_CH-1:0] wr;
   logic [NUM_CH-1:0] dirty;

   always_comb begin
      commit = (cnt_q == CNT_W'(PERIOD_TICKS - 1));
      cnt_d  = commit ? '0 : cnt_q + CNT_W'(1);
      // Outputs lag the counter by one cycle, so the flag lines up with the
      // pwm_out cycle that reflects counter == 0.
      fs_d   = (cnt_q == '0);
      pend_d = |dirty;
   end

   always_ff @(posedge clkdiv) begin
      if (rst) begin
         cnt_q  <= '0;
         fs_q   <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         fs_q   <= fs_d;
         pend_q <= pend_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Selector codes at or above NUM_CH match no channel and are dropped.
      assign wr[i] = load && (ch_sel == CH_W'(i));

      servo_pwm_cmp #(
         .DUTY_W    (DUTY_W),
         .CNT_W     (CNT_W),
         .MIN_TICKS (MIN_TICKS)
      ) u_cmp (
         .clk_i    (clkdiv),
         .rst_i    (rst),
         .wr_i     (wr[i]),
         .wdata_i  (dutycycle),
         .commit_i (commit),
         .en_i     (ch_en[i]),
         .cnt_i    (cnt_q),
         .dirty_o  (dirty[i]),
         .pwm_o    (pwm_out[i])
      );
   end

   assign frame_start = fs_q;
   assign pending     = pend_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: per-frame high-time scoreboard plus
// spot checks of reset, pending and frame period.
module tb_servo_pwm_bank;

   localparam int NCH = 6;     // leaves selector codes 6 and 7 out of range
   localparam int DW  = 8;
   localparam int CW  = 3;
   localparam int P   = 2560;
   localparam int MIN = 64;

   logic           clkdiv = 1'b0;
   logic           rst;
   logic           load;
   logic [CW-1:0]  ch_sel;
   logic [DW-1:0]  dutycycle;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] pwm_out;
   logic           frame_start;
   logic           pending;

   always #5 clkdiv = ~clkdiv;

   servo_pwm_bank #(
      .NUM_CH       (NCH),
      .DUTY_W       (DW),
      .PERIOD_TICKS (P),
      .MIN_TICKS    (MIN)
   ) dut (
      .clkdiv      (clkdiv),
      .rst         (rst),
      .load        (load),
      .ch_sel      (ch_sel),
      .dutycycle   (dutycycle),
      .ch_en       (ch_en),
      .pwm_out     (pwm_out),
      .frame_start (frame_start),
      .pending     (pending)
   );

   typedef struct {
      int                    fno;
      logic [NCH-1:0][11:0]  hi;
   } exp_t;

   exp_t                 q[$];
   logic [NCH-1:0][11:0] exp_hi;
   int                   n_cmp = 0;
   int                   n_err = 0;
   int                   fno;
   int                   pos;
   int                   cnt_hi[NCH];
   bit                   in_frame;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_all(input int v);
      for (int i = 0; i < NCH; i++) exp_hi[i] = 12'(v);
   endtask

   task automatic push(input int f);
      exp_t e;
      e.fno = f;
      e.hi  = exp_hi;
      q.push_back(e);
   endtask

   task automatic close_frame();
      chk("frame_period", pos, P - 1);
      while (q.size() > 0 && q[0].fno < fno) begin
         chk("exp_skipped", fno, q[0].fno);
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].fno == fno) begin
         for (int i = 0; i < NCH; i++)
            chk($sformatf("f%0d_ch%0d_hi", fno, i), cnt_hi[i], int'(q[0].hi[i]));
         void'(q.pop_front());
      end
   endtask

   // One clock: sample on the falling edge and track frame windows.
   task automatic tick();
      @(negedge clkdiv);
      if (rst) begin
         in_frame = 1'b0;
         fno      = -1;
         pos      = 0;
      end else begin
         if (frame_start) begin
            if (in_frame) close_frame();
            fno++;
            in_frame = 1'b1;
            pos      = 0;
            for (int i = 0; i < NCH; i++) cnt_hi[i] = 0;
         end else begin
            pos++;
         end
         for (int i = 0; i < NCH; i++) cnt_hi[i] += int'(pwm_out[i]);
      end
   endtask

   // Stop one cycle early so the next driven input is sampled at counter c.
   task automatic go_to(input int c);
      int n = 0;
      while (!(in_frame && pos == c - 1)) begin
         tick();
         n++;
         if (n > 3 * P) begin
            chk("go_to_timeout", n, 0);
            return;
         end
      end
   endtask

   task automatic wait_fs();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!frame_start && n <= 2 * P);
      if (!frame_start) chk("fs_timeout", int'(frame_start), 1);
   endtask

   task automatic do_load(input int ch, input int val);
      ch_sel    = CW'(ch);
      dutycycle = DW'(val);
      load      = 1'b1;
      tick();
      load      = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; ch_sel = '0; dutycycle = '0; ch_en = '0;
      in_frame = 1'b0; fno = -1; pos = 0;
      for (int i = 0; i < NCH; i++) cnt_hi[i] = 0;
      repeat (2) tick();
      // a write while in reset must not stick
      ch_sel = 3'd2; dutycycle = 8'd77; load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_pending", int'(pending), 0);

      ch_en = '1;
      rst   = 1'b0;
      tick();
      chk("fs_after_rst", int'(frame_start), 1);
      set_all(0);   push(0);   // enables not captured until the first frame end
      set_all(MIN); push(1);

      wait_fs();
      go_to(1000);
      do_load(3, 255);
      repeat (3) tick();
      chk("pending_set", int'(pending), 1);
      exp_hi[3] = 12'(MIN + 255);
      push(2);

      wait_fs();
      repeat (4) tick();
      chk("pending_clr", int'(pending), 0);
      go_to(500);
      do_load(6, 200);
      do_load(7, 50);
      repeat (3) tick();
      chk("pending_oor", int'(pending), 0);
      push(3);

      wait_fs();
      exp_hi[0] = 12'(MIN + 200);
      push(4);
      go_to(100);
      do_load(0, 10);
      go_to(900);
      do_load(0, 200);
      go_to(P - 1);
      do_load(1, 40);
      repeat (4) tick();
      chk("pending_late", int'(pending), 1);
      exp_hi[1] = 12'(MIN + 40);
      push(5);

      wait_fs();
      repeat (4) tick();
      chk("pending_clr2", int'(pending), 0);
      go_to(30);
      ch_en[5] = 1'b0;
      exp_hi[5] = 12'd0;
      push(6);

      wait_fs();
      go_to(200);
      do_load(2, 100);

      wait_fs();
      go_to(164);
      chk("ch2_last_hi", int'(pwm_out[2]), 1);
      tick();
      chk("ch2_first_lo", int'(pwm_out[2]), 0);
      rst = 1'b1;
      tick();
      chk("abort_pwm", int'(pwm_out), 0);
      chk("abort_fs", int'(frame_start), 0);
      chk("abort_pending", int'(pending), 0);
      tick();
      ch_en = '1;
      rst   = 1'b0;
      tick();
      chk("fs_after_rst2", int'(frame_start), 1);
      set_all(0);   push(0);
      set_all(MIN); push(1);
      wait_fs();
      wait_fs();
      chk("exp_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
